// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported unified instruction/data memory between the fetch
// stage (IF port) and the load/store unit (D port). One requester is granted
// at a time; the access is presented on a req/ready handshake that tolerates
// any number of wait states, and the winner gets a one-cycle ack with its read
// data. Data accesses win contested arbitration, except that after
// STARVE_LIMIT consecutive contested D grants the next contested arbitration
// goes to IF.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   if_req/if_addr           fetch request, held until if_ack
//   if_rdata/if_ack          fetched word and one-cycle completion pulse
//   d_req/d_we/d_be/d_addr/d_wdata   load/store request, held until d_ack
//   d_rdata/d_ack            load data and one-cycle completion pulse
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata   memory access, registered
//   mem_rdata/mem_ready      memory read data and completion strobe
//   busy                     high while an access is in ACCESS or RESP
//   owner                    current/last grant: 0=IF, 1=D
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [31:0]   if_rdata,
  output logic          if_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_be,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic [31:0]   d_rdata,
  output logic          d_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ready,
  output logic          busy,
  output logic          owner
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t     state;
  logic [3:0] starve_cnt;
  logic       grant_d;

  // D wins whenever it asks, unless IF is also asking and has already been
  // passed over LIMIT times in a row.
  always_comb begin
    grant_d = d_req && (!if_req || (starve_cnt != LIMIT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= 4'h0;
      mem_addr   <= '0;
      mem_wdata  <= 32'h0;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      if_rdata   <= 32'h0;
      d_rdata    <= 32'h0;
      owner      <= 1'b0;
      busy       <= 1'b0;
      starve_cnt <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            state   <= ACCESS;
            mem_req <= 1'b1;
            busy    <= 1'b1;
            owner   <= grant_d;
            if (grant_d) begin
              mem_we    <= d_we;
              mem_be    <= d_be;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              // Only a contested D grant counts toward starving IF.
              if (if_req && (starve_cnt != LIMIT)) begin
                starve_cnt <= starve_cnt + 4'h1;
              end
            end else begin
              mem_we     <= 1'b0;
              mem_be     <= 4'hF;
              mem_addr   <= if_addr;
              mem_wdata  <= 32'h0;
              starve_cnt <= 4'h0;
            end
          end
        end

        ACCESS: begin
          if (mem_ready) begin
            state   <= RESP;
            mem_req <= 1'b0;
            if (owner) begin
              d_ack <= 1'b1;
              // Stores leave the last load result in place.
              if (!mem_we) begin
                d_rdata <= mem_rdata;
              end
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end
        end

        RESP: begin
          state  <= IDLE;
          if_ack <= 1'b0;
          d_ack  <= 1'b0;
          busy   <= 1'b0;
        end

        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          if_ack  <= 1'b0;
          d_ack   <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter. Two requester processes replay
// per-port request queues, a memory process answers the mem_* handshake with
// programmable or random wait states, and each test task compares the logged
// results with a reference memory and a grant-order model.
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dop_t;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    int          cyc;
  } if_done_t;
  typedef struct {
    dop_t        op;
    logic [31:0] rdata;
    int          cyc;
  } d_done_t;
  typedef struct {
    logic owner;
    dop_t f;
    logic stable;
    int   cycles;
  } acc_t;

  logic        clk, rst;
  logic        if_req, if_ack;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_ack;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_ready;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy, owner;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT), .AW(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .owner(owner)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int wait_mode = 0;   // 0: fixed_wait wait states, 1: random 0..3
  int fixed_wait = 0;
  int gap_mode = 0;    // 1: requesters idle 0..3 cycles between requests
  int if_spur = 0;
  int d_spur = 0;

  logic [31:0] if_pend[$];
  dop_t        d_pend[$];
  if_done_t    if_done[$];
  d_done_t     d_done[$];
  acc_t        acc_log[$];
  logic [31:0] ref_mem[256];
  logic [31:0] phys[256];

  function automatic logic [31:0] init_word(int i);
    if (i == 4) return 32'h00500093;
    return (32'h3C00_0000 ^ (32'(i) * 32'h0001_0203)) | 32'h1;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory model: answers each access after the selected number of wait
  // states and logs the fields seen during the whole access.
  initial begin
    acc_t cur;
    int   wait_left;
    logic active;
    for (int i = 0; i < 256; i++) phys[i] = init_word(i);
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    active = 1'b0;
    wait_left = 0;
    cur = '{1'b0, '{1'b0, 4'h0, 32'h0, 32'h0}, 1'b1, 0};
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (!active) begin
          active = 1'b1;
          cur.f = '{mem_we, mem_be, mem_addr, mem_wdata};
          cur.stable = 1'b1;
          cur.cycles = 0;
          wait_left = (wait_mode != 0) ? int'($urandom_range(0, 3)) : fixed_wait;
        end else if ({mem_we, mem_be, mem_addr, mem_wdata} !== {cur.f.we, cur.f.be, cur.f.addr, cur.f.wdata}) begin
          cur.stable = 1'b0;
        end
        cur.cycles++;
        if (wait_left == 0) begin
          mem_ready = 1'b1;
          mem_rdata = phys[mem_addr[9:2]];
          if (mem_we) phys[mem_addr[9:2]] = merge(phys[mem_addr[9:2]], mem_wdata, mem_be);
          cur.owner = owner;
          acc_log.push_back(cur);
          active = 1'b0;
        end else begin
          mem_ready = 1'b0;
          mem_rdata = $urandom;
          wait_left--;
        end
      end else begin
        active = 1'b0;
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
    end
  end

  // IF requester: presents queued fetch addresses, re-requests right after ack.
  initial begin
    int   if_idx, if_gap;
    logic if_busy;
    if_req = 1'b0; if_addr = 32'h0; if_busy = 1'b0; if_idx = 0; if_gap = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if_busy = 1'b0;
        if_idx = if_pend.size();
      end else begin
        if (if_ack) begin
          if (if_busy) if_done.push_back('{if_addr, if_rdata, cyc});
          else if_spur++;
          if_busy = 1'b0;
          if_gap = (gap_mode != 0) ? int'($urandom_range(0, 3)) : 0;
        end
        if (!if_busy && if_idx < if_pend.size()) begin
          if (if_gap > 0) if_gap--;
          else begin
            if_addr = if_pend[if_idx];
            if_idx++;
            if_busy = 1'b1;
          end
        end
      end
      if_req = if_busy;
    end
  end

  // D requester: same policy for loads/stores.
  initial begin
    int   d_idx, d_gap;
    logic d_busy;
    dop_t d_cur;
    d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
    d_busy = 1'b0; d_idx = 0; d_gap = 0;
    d_cur = '{1'b0, 4'h0, 32'h0, 32'h0};
    forever begin
      @(negedge clk);
      if (rst) begin
        d_busy = 1'b0;
        d_idx = d_pend.size();
      end else begin
        if (d_ack) begin
          if (d_busy) d_done.push_back('{d_cur, d_rdata, cyc});
          else d_spur++;
          d_busy = 1'b0;
          d_gap = (gap_mode != 0) ? int'($urandom_range(0, 3)) : 0;
        end
        if (!d_busy && d_idx < d_pend.size()) begin
          if (d_gap > 0) d_gap--;
          else begin
            d_cur = d_pend[d_idx];
            d_idx++;
            d_busy = 1'b1;
          end
        end
      end
      d_req = d_busy;
      d_we = d_cur.we; d_be = d_cur.be; d_addr = d_cur.addr; d_wdata = d_cur.wdata;
    end
  end

  task automatic pulse_reset();
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
    n_checks++; if (mem_be !== 4'h0) begin n_fail++; $display("FAIL reset_mem_be: got %h expected 0", mem_be); end
    n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    n_checks++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h expected 0", mem_wdata); end
    n_checks++; if ({if_ack, d_ack} !== 2'b00) begin n_fail++; $display("FAIL reset_acks: got %b expected 00", {if_ack, d_ack}); end
    n_checks++; if (if_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_if_rdata: got %h expected 0", if_rdata); end
    n_checks++; if (d_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_d_rdata: got %h expected 0", d_rdata); end
    n_checks++; if ({owner, busy} !== 2'b00) begin n_fail++; $display("FAIL reset_owner_busy: got %b expected 00", {owner, busy}); end
    @(posedge clk); #2 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if ({mem_req, busy} !== 2'b00) begin n_fail++; $display("FAIL idle_no_req: got %b expected 00", {mem_req, busy}); end
    end
    $display("test_reset done");
  endtask

  task automatic test_single_fetch();
    fixed_wait = 0;
    @(posedge clk); #1 if_pend.push_back(32'h10);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h10}) begin
      n_fail++; $display("FAIL fetch_bus: got req=%b we=%b be=%h addr=%h expected 1 0 f 00000010", mem_req, mem_we, mem_be, mem_addr);
    end
    @(negedge clk);
    n_checks++;
    if ({if_ack, d_ack, owner} !== 3'b100) begin
      n_fail++; $display("FAIL fetch_ack: got if_ack=%b d_ack=%b owner=%b expected 1 0 0", if_ack, d_ack, owner);
    end
    n_checks++;
    if (if_rdata !== 32'h00500093) begin n_fail++; $display("FAIL fetch_rdata: got %h expected 00500093", if_rdata); end
    @(negedge clk);
    n_checks++;
    if (if_ack !== 1'b0) begin n_fail++; $display("FAIL fetch_ack_pulse: got %b expected 0", if_ack); end
    $display("test_single_fetch: addr=00000010 rdata=%h", if_rdata);
  endtask

  task automatic test_back_to_back();
    int ib;
    fixed_wait = 0;
    ib = if_done.size();
    @(posedge clk); #1
    if_pend.push_back(32'h0); if_pend.push_back(32'h4); if_pend.push_back(32'h8);
    for (int k = 0; k < 40 && if_done.size() < ib + 3; k++) @(negedge clk);
    n_checks++;
    if (if_done.size() < ib + 3) begin
      n_fail++; $display("FAIL b2b_timeout: got %0d acks expected 3", if_done.size() - ib);
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (if_done[ib+k].rdata !== ref_mem[if_done[ib+k].addr[9:2]]) begin
          n_fail++; $display("FAIL b2b_rdata: got %h expected %h", if_done[ib+k].rdata, ref_mem[if_done[ib+k].addr[9:2]]);
        end
        if (k > 0) begin
          n_checks++;
          if (if_done[ib+k].cyc - if_done[ib+k-1].cyc != 3) begin
            n_fail++; $display("FAIL b2b_spacing: got %0d expected 3", if_done[ib+k].cyc - if_done[ib+k-1].cyc);
          end
        end
        $display("test_back_to_back: addr=%h rdata=%h cyc=%0d", if_done[ib+k].addr, if_done[ib+k].rdata, if_done[ib+k].cyc);
      end
    end
  endtask

  task automatic test_store_waits();
    dop_t op;
    op = '{1'b1, 4'b0011, 32'h104, 32'hDEADBEEF};
    fixed_wait = 3;
    @(posedge clk); #1 d_pend.push_back(op);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, op.we, op.be, op.addr, op.wdata}) begin
        n_fail++; $display("FAIL store_bus_cycle%0d: got req=%b we=%b be=%h addr=%h wdata=%h expected 1 1 3 00000104 deadbeef",
                           k, mem_req, mem_we, mem_be, mem_addr, mem_wdata);
      end
      n_checks++;
      if ({if_ack, d_ack} !== 2'b00) begin n_fail++; $display("FAIL store_early_ack: got %b expected 00", {if_ack, d_ack}); end
    end
    @(negedge clk);
    n_checks++;
    if ({d_ack, if_ack, mem_req} !== 3'b100) begin
      n_fail++; $display("FAIL store_ack: got d_ack=%b if_ack=%b mem_req=%b expected 1 0 0", d_ack, if_ack, mem_req);
    end
    n_checks++;
    if (d_rdata !== 32'h0) begin n_fail++; $display("FAIL store_d_rdata: got %h expected 00000000", d_rdata); end
    @(negedge clk);
    n_checks++;
    if ({d_ack, busy} !== 2'b00) begin n_fail++; $display("FAIL store_after: got %b expected 00", {d_ack, busy}); end
    ref_mem[op.addr[9:2]] = merge(ref_mem[op.addr[9:2]], op.wdata, op.be);
    fixed_wait = 0;
    $display("test_store_waits: addr=%h be=%h wdata=%h", op.addr, op.be, op.wdata);
  endtask

  task automatic test_contention();
    int ib, db, ab;
    pulse_reset();
    fixed_wait = 0;
    ib = if_done.size(); db = d_done.size(); ab = acc_log.size();
    @(posedge clk); #1
    if_pend.push_back(32'h40);
    d_pend.push_back('{1'b0, 4'hF, 32'h258, 32'h0});
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({mem_req, owner} !== 2'b11) begin n_fail++; $display("FAIL contend_first: got req=%b owner=%b expected 1 1", mem_req, owner); end
    n_checks++;
    if (dut.starve_cnt !== 4'd1) begin n_fail++; $display("FAIL contend_cnt1: got %0d expected 1", dut.starve_cnt); end
    for (int k = 0; k < 30 && (if_done.size() < ib + 1 || d_done.size() < db + 1); k++) @(negedge clk);
    n_checks++;
    if (if_done.size() < ib + 1 || d_done.size() < db + 1 || acc_log.size() < ab + 2) begin
      n_fail++; $display("FAIL contend_timeout: got if=%0d d=%0d expected 1 1", if_done.size() - ib, d_done.size() - db);
    end else begin
      n_checks++;
      if ({acc_log[ab].owner, acc_log[ab+1].owner} !== 2'b10) begin
        n_fail++; $display("FAIL contend_order: got %b expected 10", {acc_log[ab].owner, acc_log[ab+1].owner});
      end
      n_checks++;
      if (if_done[ib].cyc - d_done[db].cyc != 3) begin
        n_fail++; $display("FAIL contend_if_delay: got %0d expected 3", if_done[ib].cyc - d_done[db].cyc);
      end
      n_checks++;
      if (d_done[db].rdata !== ref_mem[150] || if_done[ib].rdata !== ref_mem[16]) begin
        n_fail++; $display("FAIL contend_rdata: got %h %h expected %h %h", d_done[db].rdata, if_done[ib].rdata, ref_mem[150], ref_mem[16]);
      end
      n_checks++;
      if (dut.starve_cnt !== 4'd0) begin n_fail++; $display("FAIL contend_cnt0: got %0d expected 0", dut.starve_cnt); end
      $display("test_contention: D ack cyc=%0d IF ack cyc=%0d", d_done[db].cyc, if_done[ib].cyc);
    end
  endtask

  task automatic test_starvation();
    int   ab, ni, nd, cnt;
    logic exp_order[$];
    pulse_reset();
    fixed_wait = 0;
    ab = acc_log.size();
    @(posedge clk); #1
    for (int k = 0; k < 4; k++) if_pend.push_back(32'(k * 4));
    for (int k = 0; k < 12; k++) d_pend.push_back('{1'b0, 4'hF, 32'h200 + 32'(k * 4), 32'h0});
    // Grant order when both sides always have a request waiting.
    ni = 4; nd = 12; cnt = 0;
    while (ni > 0 || nd > 0) begin
      if (nd > 0 && (ni == 0 || cnt != LIMIT)) begin
        exp_order.push_back(1'b1);
        if (ni > 0 && cnt < LIMIT) cnt++;
        nd--;
      end else begin
        exp_order.push_back(1'b0);
        cnt = 0;
        ni--;
      end
    end
    for (int k = 0; k < 200 && acc_log.size() < ab + 16; k++) @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (acc_log.size() != ab + 16) begin
      n_fail++; $display("FAIL starve_count: got %0d accesses expected 16", acc_log.size() - ab);
    end else begin
      for (int k = 0; k < 16; k++) begin
        n_checks++;
        if (acc_log[ab+k].owner !== exp_order[k]) begin
          n_fail++; $display("FAIL starve_grant%0d: got owner %b expected %b", k, acc_log[ab+k].owner, exp_order[k]);
        end
        $display("test_starvation: grant %0d owner=%b", k, acc_log[ab+k].owner);
      end
    end
  endtask

  task automatic test_random();
    int   ib, db, ab, ip, dp, ii, dj;
    dop_t op;
    logic [68:0] got_f, exp_f;
    wait_mode = 1; gap_mode = 1;
    ib = if_done.size(); db = d_done.size(); ab = acc_log.size();
    ip = if_pend.size(); dp = d_pend.size();
    @(posedge clk); #1
    for (int k = 0; k < 20; k++) begin
      if_pend.push_back({22'h0, 8'($urandom_range(0, 127)), 2'b00});
      op.we = 1'($urandom_range(0, 1));
      op.be = 4'($urandom_range(1, 15));
      op.addr = {22'h0, 8'($urandom_range(128, 255)), 2'b00};
      op.wdata = $urandom;
      d_pend.push_back(op);
    end
    for (int k = 0; k < 1000 && (if_done.size() < ib + 20 || d_done.size() < db + 20); k++) @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (if_done.size() != ib + 20 || d_done.size() != db + 20 || acc_log.size() != ab + 40) begin
      n_fail++; $display("FAIL rand_count: got if=%0d d=%0d acc=%0d expected 20 20 40",
                         if_done.size() - ib, d_done.size() - db, acc_log.size() - ab);
    end else begin
      for (int k = 0; k < 20; k++) begin
        n_checks++;
        if (if_done[ib+k].rdata !== ref_mem[if_done[ib+k].addr[9:2]]) begin
          n_fail++; $display("FAIL rand_if_rdata: addr=%h got %h expected %h", if_done[ib+k].addr, if_done[ib+k].rdata, ref_mem[if_done[ib+k].addr[9:2]]);
        end
        $display("test_random: IF addr=%h rdata=%h", if_done[ib+k].addr, if_done[ib+k].rdata);
      end
      for (int k = 0; k < 20; k++) begin
        op = d_done[db+k].op;
        if (op.we) begin
          ref_mem[op.addr[9:2]] = merge(ref_mem[op.addr[9:2]], op.wdata, op.be);
        end else begin
          n_checks++;
          if (d_done[db+k].rdata !== ref_mem[op.addr[9:2]]) begin
            n_fail++; $display("FAIL rand_d_rdata: addr=%h got %h expected %h", op.addr, d_done[db+k].rdata, ref_mem[op.addr[9:2]]);
          end
        end
        $display("test_random: D we=%b be=%h addr=%h wdata=%h rdata=%h", op.we, op.be, op.addr, op.wdata, d_done[db+k].rdata);
      end
      ii = 0; dj = 0;
      for (int k = 0; k < 40; k++) begin
        got_f = {acc_log[ab+k].f.we, acc_log[ab+k].f.be, acc_log[ab+k].f.addr, acc_log[ab+k].f.wdata};
        if (acc_log[ab+k].owner) begin
          exp_f = {d_pend[dp+dj].we, d_pend[dp+dj].be, d_pend[dp+dj].addr, d_pend[dp+dj].wdata};
          dj++;
        end else begin
          exp_f = {1'b0, 4'hF, if_pend[ip+ii], 32'h0};
          ii++;
        end
        n_checks++;
        if (got_f !== exp_f || acc_log[ab+k].stable !== 1'b1) begin
          n_fail++; $display("FAIL rand_bus%0d: got %h stable=%b expected %h stable=1", k, got_f, acc_log[ab+k].stable, exp_f);
        end
      end
    end
    wait_mode = 0; gap_mode = 0;
  endtask

  task automatic test_reset_mid();
    int   db, ib;
    logic saw_ack;
    fixed_wait = 0;
    db = d_done.size();
    @(posedge clk); #1 d_pend.push_back('{1'b0, 4'hF, 32'h320, 32'h0});
    for (int k = 0; k < 20 && d_done.size() < db + 1; k++) @(negedge clk);
    n_checks++;
    if (d_rdata !== ref_mem[200]) begin n_fail++; $display("FAIL rstmid_preload: got %h expected %h", d_rdata, ref_mem[200]); end
    fixed_wait = 20;
    db = d_done.size();
    @(posedge clk); #1 d_pend.push_back('{1'b0, 4'hF, 32'h324, 32'h0});
    for (int k = 0; k < 10 && mem_req !== 1'b1; k++) @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({mem_req, busy} !== 2'b11) begin n_fail++; $display("FAIL rstmid_in_access: got %b expected 11", {mem_req, busy}); end
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({mem_req, busy, d_ack} !== 3'b000) begin n_fail++; $display("FAIL rstmid_idle: got req=%b busy=%b d_ack=%b expected 0 0 0", mem_req, busy, d_ack); end
    n_checks++;
    if (d_rdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_rdata: got %h expected 00000000", d_rdata); end
    saw_ack = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (d_ack === 1'b1) saw_ack = 1'b1;
    end
    n_checks++;
    if (saw_ack !== 1'b0 || d_done.size() != db) begin n_fail++; $display("FAIL rstmid_no_ack: got ack=%b expected 0", saw_ack); end
    fixed_wait = 0;
    ib = if_done.size();
    @(posedge clk); #1 if_pend.push_back(32'h20);
    for (int k = 0; k < 20 && if_done.size() < ib + 1; k++) @(negedge clk);
    n_checks++;
    if (if_done.size() != ib + 1) begin
      n_fail++; $display("FAIL rstmid_fetch_timeout: got %0d acks expected 1", if_done.size() - ib);
    end else begin
      n_checks++;
      if (if_done[ib].rdata !== ref_mem[8]) begin n_fail++; $display("FAIL rstmid_fetch: got %h expected %h", if_done[ib].rdata, ref_mem[8]); end
      $display("test_reset_mid: post-reset fetch rdata=%h", if_done[ib].rdata);
    end
    n_checks++;
    if (if_spur != 0 || d_spur != 0) begin n_fail++; $display("FAIL spurious_acks: got if=%0d d=%0d expected 0 0", if_spur, d_spur); end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    repeat (2) @(posedge clk);
    test_reset();
    test_single_fetch();
    test_back_to_back();
    test_store_waits();
    test_contention();
    test_starvation();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
